// File: rtl/mem_arbiter.sv
// Arbitrates the single SRAM port between instruction fetch and the MEM stage.
// MEM wins ties; accesses take ACCESS_CYCLES clocks and run back-to-back while stalled.
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int AW            = 16,
  parameter int DW            = 16
) (
  input  logic          emi_clk,
  input  logic          emi_rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic [1:0]    mem_rwe,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ready,
  output logic          stall,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_dout,
  output logic          ram_data_oe,
  input  logic [DW-1:0] ram_din,
  output logic          ram_ce_n,
  output logic          ram_oe_n,
  output logic          ram_we_n,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester holds its request stable while stall=1; its ready
  // flag rises once served and stays high until an edge with stall=0.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRD  = 2'd1,
    ST_DWR  = 2'd2,
    ST_IRD  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_cnt;
  logic [3:0]    w_next_cnt;
  logic          r_if_done;
  logic          r_mem_done;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_mem_rdata;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_dout;

  logic w_mem_op;
  logic w_mem_pend;
  logic w_if_pend;
  logic w_last;
  logic w_launch;
  logic w_mem_fin;
  logic w_if_fin;
  logic w_mem_go;
  logic w_if_go;
  logic w_stall;
  logic w_ce_n;
  logic w_oe_n;
  logic w_we_n;
  logic w_data_oe;

  assign w_mem_op   = (mem_rwe == 2'b01) || (mem_rwe == 2'b10);
  assign w_mem_pend = w_mem_op & ~r_mem_done;
  assign w_if_pend  = if_req & ~r_if_done;
  assign w_last     = (r_state != ST_IDLE) && (r_cnt == LAST_CNT);
  assign w_launch   = (r_state == ST_IDLE) || w_last;
  assign w_mem_fin  = w_last && ((r_state == ST_DRD) || (r_state == ST_DWR));
  assign w_if_fin   = w_last && (r_state == ST_IRD);
  // A request finishing on this edge is not yet visible in its done flag.
  assign w_mem_go   = w_mem_pend & ~w_mem_fin;
  assign w_if_go    = w_if_pend & ~w_if_fin;

  always_ff @(posedge emi_clk or negedge emi_rst) begin
    if (!emi_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + 4'd1;
    if (w_launch) begin
      w_next_cnt = 4'd0;
      if (w_mem_go)
        w_next_state = (mem_rwe == 2'b01) ? ST_DRD : ST_DWR;
      else if (w_if_go)
        w_next_state = ST_IRD;
      else
        w_next_state = ST_IDLE;
    end
  end

  always_comb begin
    w_ce_n    = 1'b1;
    w_oe_n    = 1'b1;
    w_we_n    = 1'b1;
    w_data_oe = 1'b0;
    w_stall   = w_mem_pend | w_if_pend | (r_state != ST_IDLE);
    case (r_state)
      ST_DRD, ST_IRD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
      end
      ST_DWR: begin
        w_ce_n    = 1'b0;
        w_data_oe = 1'b1;
        // Last write cycle releases we_n while data is still driven (hold time).
        w_we_n    = (r_cnt == LAST_CNT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge emi_clk or negedge emi_rst) begin
    if (!emi_rst) begin
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_ram_addr  <= '0;
      r_ram_dout  <= '0;
    end else begin
      if (!w_stall) begin
        r_if_done  <= 1'b0;
        r_mem_done <= 1'b0;
      end else begin
        if (w_mem_fin) r_mem_done <= 1'b1;
        if (w_if_fin)  r_if_done  <= 1'b1;
      end
      if (w_mem_fin && (r_state == ST_DRD)) r_mem_rdata <= ram_din;
      if (w_if_fin) r_if_rdata <= ram_din;
      if (w_launch && w_mem_go) begin
        r_ram_addr <= mem_addr;
        if (mem_rwe == 2'b10) r_ram_dout <= mem_wdata;
      end else if (w_launch && w_if_go) begin
        r_ram_addr <= if_addr;
      end
    end
  end

  assign if_rdata    = r_if_rdata;
  assign if_ready    = r_if_done;
  assign mem_rdata   = r_mem_rdata;
  assign mem_ready   = r_mem_done;
  assign stall       = w_stall;
  assign ram_addr    = r_ram_addr;
  assign ram_dout    = r_ram_dout;
  assign ram_data_oe = w_data_oe;
  assign ram_ce_n    = w_ce_n;
  assign ram_oe_n    = w_oe_n;
  assign ram_we_n    = w_we_n;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with N=2 and one with N=4
// share the request inputs; each has its own SRAM read model.
module tb_mem_arbiter;

  logic        emi_clk = 1'b0;
  logic        emi_rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic [1:0]  mem_rwe = 2'b00;
  logic [15:0] mem_addr = 16'h0;
  logic [15:0] mem_wdata = 16'h0;

  logic [15:0] if_rdata, mem_rdata, ram_addr, ram_dout, ram_din;
  logic        if_ready, mem_ready, stall, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
  logic [1:0]  dbg_state;

  logic [15:0] if_rdata_4, mem_rdata_4, ram_addr_4, ram_dout_4, ram_din_4;
  logic        if_ready_4, mem_ready_4, stall_4, ram_data_oe_4, ram_ce_n_4, ram_oe_n_4, ram_we_n_4;
  logic [1:0]  dbg_state_4;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 emi_clk = ~emi_clk;

  function automatic logic [15:0] ram_model(input logic [15:0] a);
    case (a)
      16'h0040: return 16'h6A01;
      16'h9000: return 16'h1234;
      16'h0041: return 16'h0800;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  assign ram_din   = ram_model(ram_addr);
  assign ram_din_4 = ram_model(ram_addr_4);

  mem_arbiter #(.ACCESS_CYCLES(2), .AW(16), .DW(16)) u_dut2 (
    .emi_clk(emi_clk), .emi_rst(emi_rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rwe(mem_rwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_data_oe(ram_data_oe), .ram_din(ram_din),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .dbg_state(dbg_state)
  );

  mem_arbiter #(.ACCESS_CYCLES(4), .AW(16), .DW(16)) u_dut4 (
    .emi_clk(emi_clk), .emi_rst(emi_rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_4), .if_ready(if_ready_4),
    .mem_rwe(mem_rwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata_4), .mem_ready(mem_ready_4), .stall(stall_4),
    .ram_addr(ram_addr_4), .ram_dout(ram_dout_4), .ram_data_oe(ram_data_oe_4), .ram_din(ram_din_4),
    .ram_ce_n(ram_ce_n_4), .ram_oe_n(ram_oe_n_4), .ram_we_n(ram_we_n_4), .dbg_state(dbg_state_4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge emi_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge emi_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nce;
    logic [15:0] exp_d;

    // Reset values
    #2;
    check_eq("rst ce_n", ram_ce_n, 1'b1);
    check_eq("rst oe_n", ram_oe_n, 1'b1);
    check_eq("rst we_n", ram_we_n, 1'b1);
    check_eq("rst data_oe", ram_data_oe, 1'b0);
    check_eq("rst stall", stall, 1'b0);
    check_eq("rst readies", {if_ready, mem_ready}, 2'b00);
    check_eq("rst ram_addr", ram_addr, 16'h0);
    check_eq("rst state", dbg_state, 2'd0);
    mid();
    mid();
    emi_rst = 1'b1;
    idle(2);

    // Single fetch, N=2
    if_req = 1'b1; if_addr = 16'h0040;
    mid();
    check_eq("t2 c0 stall", stall, 1'b1);
    check_eq("t2 c0 ce_n", ram_ce_n, 1'b1);
    cyc(); mid();
    check_eq("t2 c1 stall", stall, 1'b1);
    check_eq("t2 c1 ce/oe/we", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b001);
    check_eq("t2 c1 addr", ram_addr, 16'h0040);
    check_eq("t2 c1 ready", if_ready, 1'b0);
    cyc(); mid();
    check_eq("t2 c2 stall", stall, 1'b1);
    check_eq("t2 c2 ce/oe/we", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b001);
    cyc(); mid();
    check_eq("t2 c3 ready", if_ready, 1'b1);
    check_eq("t2 c3 rdata", if_rdata, 16'h6A01);
    check_eq("t2 c3 stall", stall, 1'b0);
    check_eq("t2 c3 ce_n", ram_ce_n, 1'b1);
    if_req = 1'b0;
    cyc(); mid();
    check_eq("t2 c4 ready clr", if_ready, 1'b0);
    idle(8);

    // Single write, N=2
    mem_rwe = 2'b10; mem_addr = 16'h8000; mem_wdata = 16'hBEEF;
    cyc(); mid();
    check_eq("t3 c1 ce/oe/we", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b010);
    check_eq("t3 c1 data_oe", ram_data_oe, 1'b1);
    check_eq("t3 c1 dout", ram_dout, 16'hBEEF);
    check_eq("t3 c1 addr", ram_addr, 16'h8000);
    cyc(); mid();
    check_eq("t3 c2 ce/oe/we", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b011);
    check_eq("t3 c2 data_oe", ram_data_oe, 1'b1);
    check_eq("t3 c2 dout", ram_dout, 16'hBEEF);
    cyc(); mid();
    check_eq("t3 c3 ready", mem_ready, 1'b1);
    check_eq("t3 c3 stall", stall, 1'b0);
    check_eq("t3 c3 data_oe", ram_data_oe, 1'b0);
    mem_rwe = 2'b00;
    cyc(); mid();
    check_eq("t3 c4 ready clr", mem_ready, 1'b0);
    idle(8);

    // Simultaneous MEM read and fetch: MEM first
    mem_rwe = 2'b01; mem_addr = 16'h9000; if_req = 1'b1; if_addr = 16'h0041;
    cyc(); mid();
    check_eq("t4 c1 addr", ram_addr, 16'h9000);
    check_eq("t4 c1 oe_n", ram_oe_n, 1'b0);
    check_eq("t4 c1 stall", stall, 1'b1);
    cyc(); mid();
    check_eq("t4 c2 mem_ready", mem_ready, 1'b0);
    cyc(); mid();
    check_eq("t4 c3 mem_ready", mem_ready, 1'b1);
    check_eq("t4 c3 mem_rdata", mem_rdata, 16'h1234);
    check_eq("t4 c3 addr", ram_addr, 16'h0041);
    check_eq("t4 c3 oe_n", ram_oe_n, 1'b0);
    check_eq("t4 c3 stall", stall, 1'b1);
    check_eq("t4 c3 if_ready", if_ready, 1'b0);
    cyc(); mid();
    check_eq("t4 c4 stall", stall, 1'b1);
    check_eq("t4 c4 if_ready", if_ready, 1'b0);
    cyc(); mid();
    check_eq("t4 c5 if_ready", if_ready, 1'b1);
    check_eq("t4 c5 if_rdata", if_rdata, 16'h0800);
    check_eq("t4 c5 mem_ready", mem_ready, 1'b1);
    check_eq("t4 c5 stall", stall, 1'b0);
    mem_rwe = 2'b00; if_req = 1'b0;
    idle(12);

    // mem_rwe=11 is not an operation
    mem_rwe = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc(); mid();
      check_eq($sformatf("t5a c%0d stall", i), stall, 1'b0);
      check_eq($sformatf("t5a c%0d ce_n", i), ram_ce_n, 1'b1);
      check_eq($sformatf("t5a c%0d mem_ready", i), mem_ready, 1'b0);
    end
    mem_rwe = 2'b00;
    idle(12);

    // Back-to-back fetches 0..3
    for (int i = 0; i < 4; i++) begin
      cyc();
      if_req = 1'b1; if_addr = 16'(i);
      exp_q.push_back(ram_model(16'(i)));
      lat = 0; nce = 0;
      for (int k = 0; k < 20; k++) begin
        cyc(); mid();
        lat++;
        if (!ram_ce_n) nce++;
        if (if_ready) break;
      end
      exp_d = exp_q.pop_front();
      check_eq($sformatf("t5b f%0d latency", i), lat, 3);
      check_eq($sformatf("t5b f%0d active", i), nce, 2);
      check_eq($sformatf("t5b f%0d rdata", i), if_rdata, exp_d);
    end
    if_req = 1'b0;
    idle(12);

    // Reset in the middle of a write
    mem_rwe = 2'b10; mem_addr = 16'h8000; mem_wdata = 16'h1111;
    cyc(); mid();
    check_eq("t1 c1 we_n", ram_we_n, 1'b0);
    emi_rst = 1'b0; mem_rwe = 2'b00;
    #1;
    check_eq("t1 rst ce/oe/we", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
    check_eq("t1 rst data_oe", ram_data_oe, 1'b0);
    check_eq("t1 rst stall", stall, 1'b0);
    check_eq("t1 rst state", dbg_state, 2'd0);
    mid();
    emi_rst = 1'b1;
    cyc(); mid();
    check_eq("t1 post stall", stall, 1'b0);
    check_eq("t1 post readies", {if_ready, mem_ready}, 2'b00);
    check_eq("t1 post ce_n", ram_ce_n, 1'b1);
    idle(4);

    // N=4 read on the second instance
    mem_rwe = 2'b01; mem_addr = 16'h9000;
    for (int c = 1; c <= 4; c++) begin
      cyc(); mid();
      check_eq($sformatf("t6 c%0d oe_n", c), ram_oe_n_4, 1'b0);
      check_eq($sformatf("t6 c%0d ready", c), mem_ready_4, 1'b0);
      check_eq($sformatf("t6 c%0d stall", c), stall_4, 1'b1);
    end
    cyc(); mid();
    check_eq("t6 c5 ready", mem_ready_4, 1'b1);
    check_eq("t6 c5 rdata", mem_rdata_4, 16'h1234);
    check_eq("t6 c5 stall", stall_4, 1'b0);
    check_eq("t6 c5 oe_n", ram_oe_n_4, 1'b1);
    mem_rwe = 2'b00;
    cyc(); mid();
    check_eq("t6 c6 ready clr", mem_ready_4, 1'b0);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
